ofifo_drain: RTL and testbench

//  Reader side of the output FIFO: pops full rows (all col lanes) from the

---
 rtl/ofifo_drain_pkg.sv | 17 +
 rtl/relu_lane.sv | 20 ++
 rtl/ofifo_drain.sv | 128 ++++++++++++
 tb/tb_ofifo_drain.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofifo_drain_pkg.sv
// Shared definitions for the ofifo drain engine.
//   state_e      : drain FSM state encoding
//   *_default    : default geometry (col lanes, lane width, SRAM address width)
package ofifo_drain_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrain = 2'd1,
        StFlush = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned col_default     = 8;
    localparam int unsigned psum_bw_default = 16;
    localparam int unsigned addr_w_default  = 11;

endpackage

// File: rtl/relu_lane.sv
// Single-lane ReLU clamp.
//   en   : 1 = clamp negative values to zero, 0 = pass through
//   din  : two's-complement lane value
//   dout : clamped lane value (combinational)
module relu_lane #(
    parameter int unsigned psum_bw = 16
) (
    input  logic               en,
    input  logic [psum_bw-1:0] din,
    output logic [psum_bw-1:0] dout
);

    always_comb begin
        dout = din;
        if (en && din[psum_bw-1]) begin
            dout = '0;
        end
    end

endmodule

// File: rtl/ofifo_drain.sv
// Reader side of the output FIFO. A start pulse latches base address, row
// count and ReLU enable, then pops num_rows full rows from the ofifo as they
// become valid, optionally clamps negative lanes, and writes each row to
// consecutive (wrapping) psum SRAM addresses. done pulses once per drain.
//   clk, reset        : clock, asynchronous active-high reset
//   start             : begin a drain (honoured only when idle)
//   base_addr         : first SRAM address
//   num_rows          : rows to drain, 0..2^addr_w
//   relu_en           : clamp negative lanes to zero
//   ofifo_valid       : head row of the ofifo is available
//   ofifo_out         : head row, lane i at [i*psum_bw +: psum_bw]
//   ofifo_rd          : pop strobe (combinational)
//   CEN, WEN, A, D    : registered SRAM write port, enables active-low
//   busy, done        : drain in progress / one-cycle completion pulse
module ofifo_drain
    import ofifo_drain_pkg::*;
#(
    parameter int unsigned col     = col_default,
    parameter int unsigned psum_bw = psum_bw_default,
    parameter int unsigned addr_w  = addr_w_default
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_w-1:0]        base_addr,
    input  logic [addr_w:0]          num_rows,
    input  logic                     relu_en,
    input  logic                     ofifo_valid,
    input  logic [col*psum_bw-1:0]   ofifo_out,
    output logic                     ofifo_rd,
    output logic                     CEN,
    output logic                     WEN,
    output logic [addr_w-1:0]        A,
    output logic [col*psum_bw-1:0]   D,
    output logic                     busy,
    output logic                     done
);

    localparam logic [addr_w:0] cnt_one = 1;

    state_e                 state;
    logic [addr_w:0]        cnt;
    logic [addr_w:0]        num_rows_q;
    logic [addr_w-1:0]      base_q;
    logic                   relu_q;
    logic [col*psum_bw-1:0] relu_row;
    logic                   last_pop;

    for (genvar i = 0; i < col; i++) begin : g_lane
        relu_lane #(
            .psum_bw(psum_bw)
        ) u_relu_lane (
            .en  (relu_q),
            .din (ofifo_out[i*psum_bw +: psum_bw]),
            .dout(relu_row[i*psum_bw +: psum_bw])
        );
    end

    assign ofifo_rd = (state == StDrain) && ofifo_valid && (cnt != num_rows_q);
    assign last_pop = (cnt + cnt_one) == num_rows_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            cnt        <= '0;
            num_rows_q <= '0;
            base_q     <= '0;
            relu_q     <= 1'b0;
            CEN        <= 1'b1;
            WEN        <= 1'b1;
            A          <= '0;
            D          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    CEN  <= 1'b1;
                    WEN  <= 1'b1;
                    done <= 1'b0;
                    if (start) begin
                        base_q     <= base_addr;
                        num_rows_q <= num_rows;
                        relu_q     <= relu_en;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        // An empty drain skips straight to the completion pulse.
                        if (num_rows == '0) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (ofifo_rd) begin
                        D   <= relu_row;
                        // Truncation to addr_w gives the modulo wrap past the top.
                        A   <= base_q + cnt[addr_w-1:0];
                        CEN <= 1'b0;
                        WEN <= 1'b0;
                        cnt <= cnt + cnt_one;
                        if (last_pop) begin
                            state <= StFlush;
                        end
                    end else begin
                        CEN <= 1'b1;
                        WEN <= 1'b1;
                    end
                end
                StFlush: begin
                    // Final write is on the pins this cycle; release the strobe.
                    CEN   <= 1'b1;
                    WEN   <= 1'b1;
                    done  <= 1'b1;
                    state <= StDone;
                end
                StDone: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ofifo_drain.sv
module tb_ofifo_drain;

    localparam int unsigned COL = 8;
    localparam int unsigned BW  = 16;
    localparam int unsigned AW  = 11;
    localparam int unsigned RW  = COL * BW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_rows = '0;
    logic          relu_en = 1'b0;
    logic          ofifo_valid = 1'b0;
    logic [RW-1:0] ofifo_out = '0;
    logic          ofifo_rd;
    logic          CEN;
    logic          WEN;
    logic [AW-1:0] A;
    logic [RW-1:0] D;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    ofifo_drain #(
        .col    (COL),
        .psum_bw(BW),
        .addr_w (AW)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .num_rows   (num_rows),
        .relu_en    (relu_en),
        .ofifo_valid(ofifo_valid),
        .ofifo_out  (ofifo_out),
        .ofifo_rd   (ofifo_rd),
        .CEN        (CEN),
        .WEN        (WEN),
        .A          (A),
        .D          (D),
        .busy       (busy),
        .done       (done)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference ofifo contents and history of every row ever pushed.
    logic [RW-1:0] fifo_q[$];
    logic [RW-1:0] all_rows[$];
    int            next_row = 0;

    bit gate_rand = 1'b0;
    bit gate_now;
    bit gate_pat[$];
    bit pend_pat[$];

    int            cyc = 0;
    int            pop_cnt = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            pop_cyc[$];
    logic [AW-1:0] wr_a[$];
    logic [RW-1:0] wr_d[$];
    int            wr_cyc[$];
    int            bad_rd = 0;
    int            bad_strobe = 0;
    bit            prev_rd = 1'b0;
    int            s_cyc = 0;
    int            p0 = 0;
    int            d0 = 0;

    // ofifo model and SRAM-port monitor: sample at negedge, drive, then
    // decide the pop that the coming rising edge will perform.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_rd = 1'b0;
        end else begin
            if (CEN !== WEN || ((CEN === 1'b0) != prev_rd)) bad_strobe++;
            if (CEN === 1'b0) begin
                wr_a.push_back(A);
                wr_d.push_back(D);
                wr_cyc.push_back(cyc);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        if (gate_pat.size() > 0) gate_now = gate_pat.pop_front();
        else if (gate_rand)      gate_now = ($urandom_range(0, 2) != 0);
        else                     gate_now = 1'b1;
        ofifo_valid = gate_now && (fifo_q.size() > 0);
        ofifo_out   = ofifo_valid ? fifo_q[0] : {$urandom, $urandom, $urandom, $urandom};
        #1;
        if (ofifo_rd === 1'b1 && (ofifo_valid !== 1'b1 || busy !== 1'b1)) bad_rd++;
        prev_rd = (ofifo_rd === 1'b1);
        if (prev_rd && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
            pop_cyc.push_back(cyc);
        end
    end

    function automatic logic [RW-1:0] relu_row(input logic [RW-1:0] r, input bit en);
        logic [RW-1:0] o;
        o = r;
        for (int i = 0; i < COL; i++) begin
            if (en && $signed(r[i*BW +: BW]) < 0) o[i*BW +: BW] = '0;
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] want);
        n_vec++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic chka(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] want);
        n_vec++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic chkb(input string tag, input logic got, input logic want);
        n_vec++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    task automatic chki(input string tag, input int got, input int want);
        n_vec++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic push_row(input logic [RW-1:0] r);
        fifo_q.push_back(r);
        all_rows.push_back(r);
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) push_row({$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic clear_logs();
        wr_a.delete();
        wr_d.delete();
        wr_cyc.delete();
        pop_cyc.delete();
        p0 = pop_cnt;
        d0 = done_cnt;
    endtask

    task automatic kick(input logic [AW-1:0] b, input int n, input bit r);
        @(negedge clk); #2;
        clear_logs();
        base_addr = b;
        num_rows  = n[AW:0];
        relu_en   = r;
        start     = 1'b1;
        s_cyc     = cyc;
        gate_pat  = pend_pat;
        pend_pat.delete();
        @(negedge clk); #2;
        start = 1'b0;
    endtask

    task automatic run_txn(input logic [AW-1:0] b, input int n, input bit r, input bit full);
        logic [AW-1:0] ea;
        kick(b, n, r);
        chkb("busy_after_start", busy, 1'b1);
        for (int k = 0; k < 400 && done_cnt == d0; k++) begin
            @(negedge clk); #2;
        end
        chki("done_pulse_count", done_cnt - d0, 1);
        @(negedge clk); #2;
        chkb("busy_after_done", busy, 1'b0);
        chkb("done_one_cycle", done, 1'b0);
        chki("pop_count", pop_cnt - p0, n);
        chki("write_count", wr_a.size(), n);
        for (int i = 0; i < n && i < wr_a.size() && next_row + i < all_rows.size(); i++) begin
            ea = AW'((int'(b) + i) % (1 << AW));
            chka("write_addr", wr_a[i], ea);
            chk("write_data", wr_d[i], relu_row(all_rows[next_row + i], r));
        end
        next_row += n;
        if (n > 0 && pop_cyc.size() > 0 && wr_cyc.size() > 0) begin
            chki("done_latency", done_cyc - pop_cyc[$], 2);
            chki("write_latency", wr_cyc[$] - pop_cyc[$], 1);
            if (full) begin
                chki("first_pop", pop_cyc[0] - s_cyc, 1);
                chki("throughput", pop_cyc[$] - pop_cyc[0], n - 1);
            end
        end
    endtask

    initial begin
        // Reset state
        #12;
        chkb("rst_rd", ofifo_rd, 1'b0);
        chkb("rst_cen", CEN, 1'b1);
        chkb("rst_wen", WEN, 1'b1);
        chka("rst_a", A, '0);
        chk("rst_d", D, '0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_done", done, 1'b0);
        @(negedge clk); #2;
        reset = 1'b0;

        // Back-to-back drain, ofifo always valid
        push_rand(4);
        run_txn(11'h010, 4, 1'b0, 1'b1);

        // Stalls from ofifo_valid gaps
        push_rand(4);
        pend_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_txn(11'h100, 4, 1'b0, 1'b0);
        if (pop_cyc.size() == 4) begin
            chki("stall_pop0", pop_cyc[0] - s_cyc, 1);
            chki("stall_pop1", pop_cyc[1] - s_cyc, 4);
            chki("stall_pop2", pop_cyc[2] - s_cyc, 5);
            chki("stall_pop3", pop_cyc[3] - s_cyc, 7);
        end

        // ReLU lane clamping
        push_row({16'hFFFE, 16'h0001, 16'hFED4, 16'h0005,
                  16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF});
        run_txn(11'h200, 1, 1'b1, 1'b1);
        if (wr_d.size() > 0) begin
            chk("relu_lanes", wr_d[0], {16'h0000, 16'h0001, 16'h0000, 16'h0005,
                                        16'h0000, 16'h7FFF, 16'h0000, 16'h0000});
        end

        // Address wrap past the top of the SRAM
        push_rand(4);
        run_txn(11'h7FE, 4, 1'b0, 1'b1);
        if (wr_a.size() == 4) begin
            chka("wrap_a2", wr_a[2], 11'h000);
            chka("wrap_a3", wr_a[3], 11'h001);
        end

        // Empty drain, plus a start pulse while busy that must be ignored
        push_rand(3);
        @(negedge clk); #2;
        clear_logs();
        base_addr = 11'h300;
        num_rows  = '0;
        relu_en   = 1'b0;
        start     = 1'b1;
        s_cyc     = cyc;
        @(negedge clk); #2;
        num_rows = 12'd3;
        chkb("empty_busy", busy, 1'b1);
        chkb("empty_done", done, 1'b1);
        @(negedge clk); #2;
        start = 1'b0;
        chkb("empty_idle", busy, 1'b0);
        repeat (6) @(negedge clk);
        #2;
        chki("empty_done_count", done_cnt - d0, 1);
        chki("empty_done_latency", done_cyc - s_cyc, 1);
        chki("empty_pops", pop_cnt - p0, 0);
        chki("empty_writes", wr_a.size(), 0);
        run_txn(11'h300, 3, 1'b1, 1'b1);

        // Reset in the middle of a drain
        push_rand(8);
        kick(11'h400, 8, 1'b0);
        for (int k = 0; k < 50 && pop_cnt - p0 < 2; k++) begin
            @(negedge clk); #2;
        end
        chki("pre_reset_pops", pop_cnt - p0, 2);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chkb("mid_rst_rd", ofifo_rd, 1'b0);
        chkb("mid_rst_cen", CEN, 1'b1);
        chkb("mid_rst_wen", WEN, 1'b1);
        chkb("mid_rst_busy", busy, 1'b0);
        @(negedge clk); #2;
        @(negedge clk); #2;
        reset = 1'b0;
        @(negedge clk); #2;
        chki("mid_rst_no_done", done_cnt - d0, 0);
        next_row += 2;
        run_txn(11'h440, 6, 1'b0, 1'b1);

        // Randomized drains with random ofifo_valid gaps
        gate_rand = 1'b1;
        for (int t = 0; t < 8; t++) begin
            int n;
            n = $urandom_range(1, 12);
            push_rand(n);
            run_txn(AW'($urandom), n, 1'($urandom), 1'b0);
        end
        gate_rand = 1'b0;

        chki("rd_rule", bad_rd, 0);
        chki("strobe_rule", bad_strobe, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
